// File: rtl/record_pkg.sv
// Shared types and helpers for the audio record engine.
// RECORD_HEADER_EN reserves the first word of each slot for the take length.
package record_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REC,
        PAUSE,
        WRITE,
        HDR,
        DONE
    } rec_state_e;

`ifdef RECORD_HEADER_EN
    localparam int unsigned HDR_OFS = 1;
`else
    localparam int unsigned HDR_OFS = 0;
`endif

    function automatic int unsigned slot_base(input int unsigned s, input int unsigned slot_words);
        return s * slot_words;
    endfunction

endpackage

// File: rtl/record_decim.sv
// Keep-1-of-DECIM sample decimator; the first accepted sample after clear is kept.
module record_decim #(
    parameter int unsigned DECIM = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic valid,
    input  logic clear,
    output logic keep_c
);

    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign keep_c = valid && (cnt_q == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (valid) begin
            if (cnt_q == CNT_W'(DECIM - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/record_engine.sv
// Multi-slot audio recorder: decimated codec samples written sequentially into an SDRAM slot.
// Defining RECORD_HEADER_EN stores the final length at the slot base after the data.
module record_engine
    import record_pkg::*;
#(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SLOT_WORDS = 2**20,
    parameter int unsigned DECIM      = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         rec_start,
    input  logic [$clog2(NUM_SLOTS)-1:0] rec_slot,
    input  logic                         rec_pause,
    input  logic                         rec_stop,
    output logic                         rec_busy,
    output logic                         rec_done,
    output logic                         rec_overflow,
    output logic [ADDR_W-1:0]            rec_length,
    output logic                         sd_write,
    output logic                         sd_read,
    output logic [ADDR_W-1:0]            sd_addr,
    output logic [DATA_W-1:0]            sd_writedata,
    input  logic                         sd_finished,
    output logic                         au_ready,
    input  logic [DATA_W-1:0]            au_data,
    input  logic                         au_valid
);

    localparam int unsigned LAST_LEN = SLOT_WORDS - HDR_OFS;
    // Without a header the take ends directly in DONE so rec_done follows stop by one cycle.
    localparam rec_state_e  END_ST   = (HDR_OFS != 0) ? HDR : DONE;

    rec_state_e        state_q;
    rec_state_e        state_d;
    logic              start_q;
    logic [ADDR_W-1:0] base_q;
    logic              pend_stop_q;
    logic              pend_pause_q;
    logic              start_c;
    logic              keep_c;
    logic              wr_last_c;
    logic [ADDR_W-1:0] len_c;

    assign au_ready  = (state_q == REC);
    assign sd_write  = (state_q == WRITE) || ((state_q == HDR) && (HDR_OFS != 0));
    assign sd_read   = 1'b0;
    assign start_c   = (state_q == IDLE) && rec_start && !start_q;
    assign wr_last_c = (rec_length + ADDR_W'(1)) == ADDR_W'(LAST_LEN);
    assign len_c     = rec_length + ADDR_W'((state_q == WRITE) && sd_finished);

    record_decim #(
        .DECIM (DECIM)
    ) u_decim (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .valid   (au_ready && au_valid),
        .clear   (start_c),
        .keep_c  (keep_c)
    );

    // Next-state decode; stop always outranks pause, and a started write always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_c) state_d = REC;
            end
            REC: begin
                if (rec_stop)       state_d = END_ST;
                else if (keep_c)    state_d = WRITE;
                else if (rec_pause) state_d = PAUSE;
            end
            PAUSE: begin
                if (rec_stop)        state_d = END_ST;
                else if (!rec_pause) state_d = REC;
            end
            WRITE: begin
                if (sd_finished) begin
                    if (wr_last_c || pend_stop_q || rec_stop)  state_d = END_ST;
                    else if (pend_pause_q || rec_pause)        state_d = PAUSE;
                    else                                       state_d = REC;
                end
            end
            HDR: begin
                if (sd_finished || (HDR_OFS == 0)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            base_q       <= '0;
            pend_stop_q  <= 1'b0;
            pend_pause_q <= 1'b0;
            rec_busy     <= 1'b0;
            rec_done     <= 1'b0;
            rec_overflow <= 1'b0;
            rec_length   <= '0;
            sd_addr      <= '0;
            sd_writedata <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= rec_start;
            rec_busy <= (state_d != IDLE);
            rec_done <= (state_d == DONE);

            if (start_c) begin
                base_q       <= ADDR_W'(slot_base(32'(rec_slot), SLOT_WORDS));
                rec_length   <= '0;
                rec_overflow <= 1'b0;
                pend_stop_q  <= 1'b0;
                pend_pause_q <= 1'b0;
            end

            if (state_q == WRITE) begin
                if (sd_finished) begin
                    rec_length   <= len_c;
                    pend_stop_q  <= 1'b0;
                    pend_pause_q <= 1'b0;
                    if (wr_last_c) rec_overflow <= 1'b1;
                end else begin
                    pend_stop_q  <= pend_stop_q || rec_stop;
                    pend_pause_q <= pend_pause_q || rec_pause;
                end
            end

            // Address and data are captured once and held for the whole write request.
            if ((state_q == REC) && (state_d == WRITE)) begin
                sd_addr      <= base_q + ADDR_W'(HDR_OFS) + rec_length;
                sd_writedata <= au_data;
            end else if ((state_d == HDR) && (state_q != HDR)) begin
                sd_addr      <= base_q;
                sd_writedata <= DATA_W'(len_c);
            end
        end
    end

endmodule

// File: tb/tb_record_engine.sv
// Scoreboard bench for record_engine: 8-word slots, keep 1 of 2 samples.
module tb_record_engine;

`ifdef RECORD_HEADER_EN
    localparam int HO = 1;
`else
    localparam int HO = 0;
`endif
    localparam int SW = 8;
    localparam int DM = 2;

    typedef struct packed {
        logic [22:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [22:0] len;
        logic        ovf;
    } dn_t;

    logic        i_clk;
    logic        i_rst_n;
    logic        rec_start;
    logic [1:0]  rec_slot;
    logic        rec_pause;
    logic        rec_stop;
    logic        rec_busy;
    logic        rec_done;
    logic        rec_overflow;
    logic [22:0] rec_length;
    logic        sd_write;
    logic        sd_read;
    logic [22:0] sd_addr;
    logic [31:0] sd_writedata;
    logic        sd_finished;
    logic        au_ready;
    logic [31:0] au_data;
    logic        au_valid;

    int  total = 0;
    int  bad = 0;
    int  dones = 0;
    int  ack_delay = 0;
    wr_t exp_wr[$];
    dn_t exp_dn[$];
    int  m_base;
    int  m_len;
    int  m_cnt;
    bit  m_ovf;

    record_engine #(
        .ADDR_W     (23),
        .DATA_W     (32),
        .NUM_SLOTS  (4),
        .SLOT_WORDS (SW),
        .DECIM      (DM)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .rec_start    (rec_start),
        .rec_slot     (rec_slot),
        .rec_pause    (rec_pause),
        .rec_stop     (rec_stop),
        .rec_busy     (rec_busy),
        .rec_done     (rec_done),
        .rec_overflow (rec_overflow),
        .rec_length   (rec_length),
        .sd_write     (sd_write),
        .sd_read      (sd_read),
        .sd_addr      (sd_addr),
        .sd_writedata (sd_writedata),
        .sd_finished  (sd_finished),
        .au_ready     (au_ready),
        .au_data      (au_data),
        .au_valid     (au_valid)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({sd_write, sd_read, rec_done, rec_busy, rec_overflow, au_ready}), 64'd0);
        chk({tag, "_len"}, 64'(rec_length), 64'd0);
        chk({tag, "_addr"}, 64'(sd_addr), 64'd0);
        chk({tag, "_data"}, 64'(sd_writedata), 64'd0);
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data);
        wr_t w;
        w.addr = 23'(addr);
        w.data = data;
        exp_wr.push_back(w);
    endtask

    task automatic model_finish();
        dn_t d;
        if (HO != 0) push_wr(m_base, 32'(m_len));
        d.len = 23'(m_len);
        d.ovf = m_ovf;
        exp_dn.push_back(d);
    endtask

    task automatic model_accept(input logic [31:0] d);
        if (m_cnt == 0) begin
            push_wr(m_base + HO + m_len, d);
            m_len++;
            if (m_len == SW - HO) begin
                m_ovf = 1'b1;
                model_finish();
            end
        end
        m_cnt = (m_cnt + 1) % DM;
    endtask

    // Acknowledges each write request ack_delay cycles after it appears.
    initial begin
        int wait_cnt = 0;
        sd_finished = 1'b0;
        forever begin
            @(negedge i_clk);
            sd_finished = 1'b0;
            if (sd_write === 1'b1) begin
                if (wait_cnt >= ack_delay) begin
                    sd_finished = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: completed writes and done pulses against the scoreboard queues.
    initial begin
        wr_t w;
        dn_t d;
        forever begin
            @(negedge i_clk);
            #1;
            if (i_rst_n && sd_write && sd_finished) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got addr %0d data %0h want none", sd_addr, sd_writedata);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 64'(sd_addr), 64'(w.addr));
                    chk("wr_data", 64'(sd_writedata), 64'(w.data));
                end
            end
            if (i_rst_n && rec_done) begin
                dones++;
                if (exp_dn.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got len %0d want no done", rec_length);
                end else begin
                    d = exp_dn.pop_front();
                    chk("done_len", 64'(rec_length), 64'(d.len));
                    chk("done_ovf", 64'(rec_overflow), 64'(d.ovf));
                end
            end
        end
    end

    task automatic start_take(input int s);
        rec_start = 1'b0;
        @(negedge i_clk);
        rec_slot  = 2'(s);
        rec_start = 1'b1;
        m_base = s * SW;
        m_len  = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        @(negedge i_clk);
        chk("start_busy", 64'(rec_busy), 64'd1);
        chk("start_ovf_clr", 64'(rec_overflow), 64'd0);
    endtask

    task automatic send(input logic [31:0] d);
        bit ok = 1'b0;
        au_data  = d;
        au_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (au_ready === 1'b1) begin
                ok = 1'b1;
                model_accept(d);
            end
            @(negedge i_clk);
        end
        au_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no au_ready want accept of %0h", d);
        end
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (dones == d0 && n < 200) begin
            @(negedge i_clk);
            #2;
            n++;
        end
        chk("done_count", 64'(dones - d0), 64'd1);
    endtask

    task automatic stop_take(input bit check_lat);
        int d0 = dones;
        model_finish();
        rec_stop = 1'b1;
        @(negedge i_clk);
        rec_stop = 1'b0;
        #2;
        if (check_lat) chk("done_latency", 64'(rec_done), (HO == 0) ? 64'd1 : 64'd0);
        wait_done(d0);
    endtask

    initial begin
        int d0;
        int hits;
        i_rst_n   = 1'b0;
        rec_start = 1'b0;
        rec_slot  = 2'd0;
        rec_pause = 1'b0;
        rec_stop  = 1'b0;
        au_valid  = 1'b0;
        au_data   = 32'd0;
        repeat (3) @(negedge i_clk);
        chk_zero("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Stop in IDLE does nothing.
        d0 = dones;
        rec_stop = 1'b1;
        @(negedge i_clk);
        rec_stop = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("idle_stop_busy", 64'(rec_busy), 64'd0);
        chk("idle_stop_done", 64'(dones - d0), 64'd0);

        // Slot 1: A0..A5 keeps A0, A2, A4.
        start_take(1);
        for (int i = 0; i < 6; i++) send(32'hA0 + 32'(i));
        stop_take(1'b1);
        repeat (3) @(negedge i_clk);
        chk("held_start_busy", 64'(rec_busy), 64'd0);

        // Slot 0: pause for 20 cycles while valid toggles.
        start_take(0);
        send(32'hB0);
        send(32'hB1);
        rec_pause = 1'b1;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (au_ready !== 1'b0) hits++;
            au_data  = 32'hEE;
            au_valid = ~au_valid;
        end
        chk("pause_ready_hits", 64'(hits), 64'd0);
        au_valid  = 1'b0;
        rec_pause = 1'b0;
        @(negedge i_clk);
        send(32'hB2);
        send(32'hB3);
        stop_take(1'b1);

        // Slot 3: stop raised while a slow write is outstanding.
        start_take(3);
        ack_delay = 5;
        send(32'hC0);
        chk("slow_wr_pending", 64'(sd_write), 64'd1);
        stop_take(1'b0);
        ack_delay = 0;

        // Slot 2: continuous samples until the slot fills.
        start_take(2);
        d0 = dones;
        for (int i = 0; i < 2 * (SW - HO) - 1; i++) send(32'hF0 + 32'(i));
        wait_done(d0);
        chk("ovf_sticky", 64'(rec_overflow), 64'd1);
        chk("ovf_ready", 64'(au_ready), 64'd0);

        // Reset during an outstanding write, then a fresh take on slot 1.
        start_take(1);
        ack_delay = 20;
        send(32'hD0);
        chk("rst_wr_active", 64'(sd_write), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_wr_drop", 64'(sd_write), 64'd0);
        chk_zero("mid_reset");
        exp_wr.delete();
        exp_dn.delete();
        ack_delay = 0;
        rec_start = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        start_take(1);
        send(32'hE0);
        send(32'hE1);
        stop_take(1'b1);

        repeat (3) @(negedge i_clk);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_dn.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
